// File: rtl/mandelbrot_iter_tracker.sv
// mandelbrot_iter_tracker: per-lane escape-iteration tracking with packed frame-buffer writeback
module mandelbrot_iter_tracker #(
  parameter int FMA_COUNT         = 12,
  parameter int DATA_WIDTH        = 16,
  parameter int FRAC_BITS         = 13,
  parameter int FB_ADDR_WIDTH     = 16,
  parameter int INSTRUCTION_WIDTH = 32
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic [0:INSTRUCTION_WIDTH-1]    instr_in,
  input  logic [15:0]                     reg_a_in,
  input  logic                            instr_valid_in,
  input  logic                            fma_result_valid_in,
  input  logic [FMA_COUNT*DATA_WIDTH-1:0] fma_x_in,
  input  logic [FMA_COUNT*DATA_WIDTH-1:0] fma_y_in,
  output logic [FB_ADDR_WIDTH-1:0]        fb_addr_out,
  output logic [FMA_COUNT*4-1:0]          fb_data_out,
  output logic                            fb_wr_out,
  output logic                            armed_out
);
  localparam logic [3:0] OP_OR   = 4'b1101;
  localparam logic [3:0] OP_SEND = 4'b1110;
  localparam int         TWO     = 1 << (FRAC_BITS + 1);
  logic [3:0]             iters [FMA_COUNT];
  logic [3:0]             iter_latch, or_val, lat;
  logic [15:0]            shifted;
  logic                   armed, wr, is_or, is_send, eval;
  logic [FMA_COUNT-1:0]   esc;
  logic [FMA_COUNT*4-1:0] packed_iters;
  always_comb begin
    is_or   = instr_valid_in && instr_in[0:3] == OP_OR;
    is_send = instr_valid_in && instr_in[0:3] == OP_SEND;
    shifted = reg_a_in >> 3;
    or_val  = shifted > 16'd14 ? 4'd14 : shifted[3:0];
    lat     = is_or ? or_val : iter_latch;
    eval    = fma_result_valid_in && (armed || is_or) && !is_send;
  end
  for (genvar i = 0; i < FMA_COUNT; i++) begin : g_lane
    logic signed [DATA_WIDTH-1:0] x, y;
    assign x = fma_x_in[i*DATA_WIDTH +: DATA_WIDTH];
    assign y = fma_y_in[i*DATA_WIDTH +: DATA_WIDTH];
    assign esc[i] = int'(x) >= TWO || int'(x) <= -TWO || int'(y) >= TWO || int'(y) <= -TWO;
    assign packed_iters[4*i +: 4] = iters[i];
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < FMA_COUNT; i++) iters[i] <= 4'hF;
      iter_latch  <= '0;
      armed       <= 1'b0;
      wr          <= 1'b0;
      fb_addr_out <= '0;
      fb_data_out <= '0;
    end else begin
      wr <= is_send;
      if (is_send) begin
        fb_addr_out <= reg_a_in[FB_ADDR_WIDTH-1:0];
        fb_data_out <= packed_iters;
        for (int i = 0; i < FMA_COUNT; i++) iters[i] <= 4'hF;
        armed <= 1'b0;
      end else begin
        if (is_or) iter_latch <= or_val;
        if (eval) begin
          for (int i = 0; i < FMA_COUNT; i++)
            if (esc[i] && iters[i] == 4'hF) iters[i] <= lat;
          armed <= 1'b0;
        end else if (is_or) armed <= 1'b1;
      end
    end
  end
  // a reset landing in the write cycle suppresses the already-registered pulse
  assign fb_wr_out = wr & ~rst_in;
  assign armed_out = armed;
endmodule

// File: doc/mandelbrot_iter_tracker.md
# mandelbrot_iter_tracker

Downstream consumer of the controller's instruction stream that implements the OR and SENDITERS opcodes. It tracks a 4-bit divergence iteration per FMA lane and tests each lane's (x, y) FMA result against the escape radius. On command it writes the packed per-lane iterations to the frame buffer, then resets the lanes for the next pixel batch. It sits beside the memory module, tapping the same instruction and register buses plus the FMA result bus.

## Interface
- FMA_COUNT, 12: number of FMA lanes (concurrent pixels).
- DATA_WIDTH, 16: bits per signed fixed-point FMA result.
- FRAC_BITS, 13: fractional bits of FMA results; 2.0 = 1 << (FRAC_BITS+1).
- FB_ADDR_WIDTH, 16: frame-buffer address width.
- INSTRUCTION_WIDTH, 32: instruction width; opcode in bits [0:3].
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous, active-high reset.
- instr_in  input  [0:INSTRUCTION_WIDTH-1]  instruction from the controller.
- reg_a_in  input  16  value of the instruction's reg_a from the controller.
- instr_valid_in  input  1  one-cycle strobe; instr_in and reg_a_in are valid this cycle.
- fma_result_valid_in  input  1  one-cycle strobe; fma_x_in and fma_y_in are valid.
- fma_x_in  input  FMA_COUNT*DATA_WIDTH  lane i real part, bits [i*DATA_WIDTH +: DATA_WIDTH], signed.
- fma_y_in  input  FMA_COUNT*DATA_WIDTH  lane i imaginary part, same packing.
- fb_addr_out  output  FB_ADDR_WIDTH  frame-buffer write address.
- fb_data_out  output  FMA_COUNT*4  packed iterations; lane i in bits [4i +: 4].
- fb_wr_out  output  1  one-cycle frame-buffer write strobe.
- armed_out  output  1  high while an OR is waiting for an FMA result.

## Operation
- Only two opcodes are decoded: OR = 4'b1101 and SENDITERS = 4'b1110. Every other opcode, and any cycle with instr_valid_in low, is ignored.
- State consists of iters[FMA_COUNT] (4 bits each), armed, and iter_latch (4 bits).
- 15 means "not yet diverged".
- OR strobe:
  - iter_latch = min(reg_a_in >> 3, 14). The clamp keeps 15 reserved.
  - armed <= 1.
  - A second OR while armed overwrites iter_latch; armed stays 1.
- Evaluation runs on a cycle with fma_result_valid_in high and armed high (or an OR strobe in the same cycle):
  - Lane i escapes if x >= 2.0, x <= -2.0, y >= 2.0, or y <= -2.0, using signed compares at full width. Exactly ±2.0 counts as escaped.
  - If lane i escapes and iters[i] == 15, set iters[i] <= iter_latch (or the same-cycle OR value).
  - Lanes that have already diverged are never overwritten.
  - armed <= 0 after the evaluation.
- An FMA beat while not armed is discarded.
- SENDITERS strobe:
  - Next cycle: fb_wr_out = 1, fb_addr_out = reg_a_in[FB_ADDR_WIDTH-1:0], fb_data_out = the iters snapshot as of the strobe cycle, before any same-cycle FMA update.
  - At the same edge all iters <= 15 and armed <= 0.
- Simultaneous SENDITERS and FMA beat: SENDITERS wins; the beat is discarded.
- OR and SENDITERS cannot coincide (single instruction bus).
- instr_valid_in held high for N cycles counts as N issues. The upstream contract is a single-cycle strobe.

## Timing
- Reset values:
  - fb_wr_out = 0, fb_addr_out = 0, fb_data_out = 0, armed_out = 0.
  - All iters = 15, iter_latch = 0.
- Reset mid-write: any fb_wr_out pulse scheduled for the next cycle is cancelled.
- OR-to-update latency: iters register at the clock edge ending the FMA-beat cycle, including a beat in the same cycle as the OR strobe.
- SENDITERS-to-write latency: 1 cycle.
  - fb_wr_out is high for exactly 1 cycle.
  - fb_addr_out and fb_data_out hold their values until the next write.
- armed_out is the registered armed flag.
- Back-to-back SENDITERS on consecutive cycles:
  - The first write carries the accumulated iters.
  - The second write carries all-15.
- Throughput: one instruction per cycle.

## Test plan
- Reset, then SENDITERS with reg_a = 0x0040 -> one cycle later fb_wr_out = 1, addr 0x0040, every nibble = 0xF; armed_out = 0.
- OR with reg_a = 40, then FMA beat with lane 0 x = 0x4000 (2.0), lane 1 y = 0xC000 (-2.0), lane 2 x = 0x3FFF, all other lanes 0; then SENDITERS -> lanes 0 and 1 = 5, all others = 15.
- OR with reg_a = 200, beat with all lanes escaping -> all lanes = 14 (clamp). Then OR with reg_a = 16 and an all-escape beat -> all lanes remain 14.
- FMA beat with no pending OR, all lanes escaping -> all lanes stay 15. Then OR and beat in the same cycle with reg_a = 24 -> all lanes = 3, armed_out = 0 after.
- SENDITERS and an escaping FMA beat in the same cycle while armed -> the write carries the pre-beat iters; afterward iters = 15 and armed_out = 0.
- Reset asserted the cycle after a SENDITERS strobe -> no fb_wr_out pulse; all outputs return to their reset values.
